feature_loader: RTL

//   Upstream/downstream wrapper for the 3-feature linear-regression datapath (X0..X2 16b in, y 32b out).

---
 rtl/feature_loader.sv | 91 +++++++++
 1 files changed

// File: rtl/feature_loader.sv
// Byte-stream loader for the 3-feature regression datapath: X0..X2 load atomically, y captured SETTLE cycles later.
// Latency: last byte accepted at edge k -> m_valid after edge k+SETTLE; s_ready low from last byte until m_y is handed off.
module feature_loader #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [15:0]      x0,
  output logic [15:0]      x1,
  output logic [15:0]      x2,
  input  logic [31:0]      y_in,
  output logic [31:0]      m_y,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_OUT} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state;
  logic [2:0]  byte_idx;
  logic [3:0]  settle_cnt;
  logic [39:0] shadow;

  assign s_ready = rst_n & ~clr & (state == ST_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      byte_idx   <= 3'd0;
      settle_cnt <= 4'd0;
      shadow     <= '0;
      x0         <= '0;
      x1         <= '0;
      x2         <= '0;
      m_y        <= '0;
      m_valid    <= 1'b0;
      frame_cnt  <= '0;
    end else if (clr) begin
      // Abort keeps the last presented features, result and count.
      state      <= ST_LOAD;
      byte_idx   <= 3'd0;
      settle_cnt <= 4'd0;
      m_valid    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (s_valid) begin
            if (byte_idx == 3'd5) begin
              // The final byte bypasses the shadow so all three features move on one edge.
              x0         <= shadow[15:0];
              x1         <= shadow[31:16];
              x2         <= {s_data, shadow[39:32]};
              byte_idx   <= 3'd0;
              settle_cnt <= 4'd0;
              state      <= ST_SETTLE;
            end else begin
              shadow[8*byte_idx +: 8] <= s_data;
              byte_idx                <= byte_idx + 3'd1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            m_y     <= y_in;
            m_valid <= 1'b1;
            state   <= ST_OUT;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
            state     <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
